// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the line-granular UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } arb_state_t;

   localparam logic [7:0] NEWLINE = 8'h0A;

   // Bits needed to count from 0 up to and including max_val.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Byte channels of the two requesters plus the downstream USB-UART bridge channel.
interface uart_tx_arbiter_if;

   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       uart_in_valid;
   logic [7:0] uart_in_data;
   logic       uart_in_ready;
   logic [1:0] owner;

   // Arbiter side.
   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data, uart_in_ready,
      output req0_ready, req1_ready, uart_in_valid, uart_in_data, owner
   );

   // Requester/bridge side.
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data, uart_in_ready,
      input  req0_ready, req1_ready, uart_in_valid, uart_in_data, owner
   );

endinterface

// File: rtl/byte_hold_reg.sv
// One-entry valid/ready holding register; loads when empty or when draining in the same cycle.
module byte_hold_reg #(
   parameter int unsigned Width = 8
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             in_valid_i,
   input  logic [Width-1:0] in_data_i,
   output logic             in_ready_o,
   output logic             out_valid_o,
   output logic [Width-1:0] out_data_o,
   input  logic             out_ready_i
);

   logic             valid_q, valid_d;
   logic [Width-1:0] data_q, data_d;

   assign in_ready_o  = !valid_q || out_ready_i;
   assign out_valid_o = valid_q;
   assign out_data_o  = data_q;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (in_valid_i && in_ready_o) begin
         valid_d = 1'b1;
         data_d  = in_data_i;
      end else if (out_ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the USB-UART transmit channel between two byte sources, granting per line with
// round-robin tie-break, a burst cap and an idle timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int unsigned MAX_BURST    = 64,
   parameter int unsigned IDLE_TIMEOUT = 1024
) (
   input logic              CLK,
   input logic              reset,
   uart_tx_arbiter_if.slave bus
);

   localparam int unsigned       BurstW   = cnt_width(MAX_BURST);
   localparam int unsigned       IdleW    = cnt_width(IDLE_TIMEOUT);
   localparam logic [BurstW-1:0] BurstMax = BurstW'(MAX_BURST);
   localparam logic [IdleW-1:0]  IdleMax  = IdleW'(IDLE_TIMEOUT);

   arb_state_t        state_q, state_d;
   logic              last_owner_q, last_owner_d;
   logic [BurstW-1:0] burst_cnt_q, burst_cnt_d;
   logic [IdleW-1:0]  idle_cnt_q, idle_cnt_d;

   logic       sel_valid;
   logic [7:0] sel_data;
   logic       hold_ready;

   byte_hold_reg #(
      .Width (8)
   ) u_hold (
      .clk_i       (CLK),
      .reset_i     (reset),
      .in_valid_i  (sel_valid),
      .in_data_i   (sel_data),
      .in_ready_o  (hold_ready),
      .out_valid_o (bus.uart_in_valid),
      .out_data_o  (bus.uart_in_data),
      .out_ready_i (bus.uart_in_ready)
   );

   assign bus.owner = {state_q == OWN1, state_q == OWN0};

   always_comb begin
      state_d        = state_q;
      last_owner_d   = last_owner_q;
      burst_cnt_d    = burst_cnt_q;
      idle_cnt_d     = idle_cnt_q;
      sel_valid      = 1'b0;
      sel_data       = bus.req0_data;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;

      unique case (state_q)
         IDLE: begin
            // last_owner_q == 1 means requester 0 wins a tie.
            if (bus.req0_valid && (!bus.req1_valid || last_owner_q)) begin
               state_d      = OWN0;
               last_owner_d = 1'b0;
            end else if (bus.req1_valid) begin
               state_d      = OWN1;
               last_owner_d = 1'b1;
            end
         end
         OWN0: begin
            sel_valid      = bus.req0_valid;
            bus.req0_ready = hold_ready;
         end
         OWN1: begin
            sel_valid      = bus.req1_valid;
            sel_data       = bus.req1_data;
            bus.req1_ready = hold_ready;
         end
         default: state_d = IDLE;
      endcase

      if (state_q == OWN0 || state_q == OWN1) begin
         if (sel_valid && hold_ready) begin
            burst_cnt_d = burst_cnt_q + BurstW'(1);
            idle_cnt_d  = '0;
            if (sel_data == NEWLINE || burst_cnt_d == BurstMax) begin
               state_d = IDLE;
            end
         end else if (sel_valid) begin
            idle_cnt_d = '0;
         end else begin
            idle_cnt_d = idle_cnt_q + IdleW'(1);
            if (idle_cnt_d == IdleMax) begin
               state_d = IDLE;
            end
         end
      end

      if (state_d == IDLE) begin
         burst_cnt_d = '0;
         idle_cnt_d  = '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q      <= IDLE;
         last_owner_q <= 1'b1;
         burst_cnt_q  <= '0;
         idle_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         last_owner_q <= last_owner_d;
         burst_cnt_q  <= burst_cnt_d;
         idle_cnt_q   <= idle_cnt_d;
      end
   end

endmodule
